delay_pipeline: RTL
===================

Name: delay_pipeline

Overview:
- Parametrised successor to the single-stage enable register: a CYCLES-deep register pipeline of WIDTH-bit data.
- Each stage carries a valid bit. The block adds a global stall (en), a valid-only flush, and a registered occupancy count.
- Used wherever a datapath needs an N-cycle delay-match with bubble tracking, e.g. aligning a side-band with a multi-cycle arithmetic unit.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- CYCLES, 4, pipeline depth and latency in cycles (>=0; 0 = combinational pass-through).
- RESET_VALUE, '0, WIDTH-bit value loaded into every data stage on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low: asserted when 0, sampled only at rising clk.
- en  in  1  advance enable; 1 = shift one stage, 0 = hold all state.
- flush  in  1  clears every valid bit at the next edge; data stages are unaffected.
- in  in  WIDTH  data input.
- valid_in  in  1  qualifies in.
- out  out  WIDTH  data output = last stage.
- valid_out  out  1  valid bit of last stage.
- count  out  max(1,$clog2(CYCLES+1))  number of stages currently holding valid=1.

Behaviour:
- Priority at each rising edge: rst==0 > flush==1 > en.
- Reset (rst==0 at edge):
  - every data stage <= RESET_VALUE; every valid bit <= 0; count <= 0.
  - en, flush, in and valid_in are ignored.
  - After the edge: out==RESET_VALUE, valid_out==0, count==0.
  - rst==0 between edges has no effect (no asynchronous path).
- Shift (rst==1, flush==0, en==1):
  - stage[0] <= in and valid[0] <= valid_in.
  - stage[i] <= stage[i-1] and valid[i] <= valid[i-1] for i=1..CYCLES-1.
  - Data shifts regardless of valid_in; data on invalid beats is don't-care but must still propagate deterministically.
- Hold (rst==1, flush==0, en==0): all data, valid bits and count unchanged. This includes in-flight valid beats, which resume when en returns to 1.
- Flush (rst==1, flush==1):
  - All valid bits <= 0 and count <= 0, regardless of en.
  - If en==1, data still shifts (stage[0] <= in), but valid[0] <= 0: flush overrides valid_in.
  - If en==0, data holds.
- Latency: with en held at 1, a beat presented at edge k appears on out/valid_out after edge k+CYCLES-1, i.e. it is visible for the cycle following that edge. Equivalently, out == $past(in, CYCLES) when en is continuously 1.
  - With stalls, latency = CYCLES enabled edges.
- count:
  - Registered; always equals the popcount of the valid bits after each edge.
  - Range 0..CYCLES, with no wrap.
  - Updated in the same edge as the valid bits; must never be derived with a one-cycle lag.
- CYCLES==0:
  - out = in, valid_out = valid_in (combinational), count = 0.
  - clk, rst, en and flush have no effect.
  - No registers inferred.
- CYCLES==1: single register with valid.
  - Without flush or valid, this reproduces the enable-register behaviour: out == $past(in, 1, en) once any enable has occurred after reset.
- All outputs are driven directly from registers (CYCLES>=1); no combinational path from inputs to outputs.

Test Plan:
- Reset with non-zero inputs (WIDTH=8, CYCLES=3, RESET_VALUE=8'hA5): rst=0 for 5 edges with in=8'hFF, valid_in=1, en=1 -> out==8'hA5, valid_out==0, count==0 after the first reset edge and on every following reset edge.
- Latency: after reset release, drive en=1, valid_in=1, in=8'h01,02,03,04 on consecutive edges -> valid_out rises after the 3rd edge with out==8'h01, then 02, 03, 04; count goes 1,2,3,3.
- Stall: pipe holds 8'h10,11,12 (all valid); hold en=0 for 4 edges while in and valid_in toggle -> out, valid_out and count stay 8'h12/1/3; on en=1, out becomes 8'h11 on the next edge.
- Flush: pipe full (count==3); flush=1, en=1, valid_in=1, in=8'h55 -> after the edge, valid_out==0 and count==0. Three further enabled valid beats 8'h20,21,22 emerge with latency 3 and nothing stale appears.
- Reset mid-stream: 2 valid beats in flight, rst=0 for one edge -> count==0 and valid_out==0 afterwards, and no in-flight beat ever emerges.
- Random soak (10000 cycles, random in/valid_in/en, flush ~2%): check valid_out/out against a reference queue, count==popcount(valid), and out==$past(in,3) whenever en stayed 1 for 3 consecutive edges. Repeat with CYCLES=0 (out==in, count==0) and CYCLES=1.

Source files
------------

// File: rtl/delay_pipeline.sv
// rtl/delay_pipeline.sv - CYCLES-deep delay pipeline with per-stage valid, stall, flush and occupancy count
module delay_pipeline #(
  parameter int WIDTH = 8,
  parameter int CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] out,
  output logic             valid_out,
  output logic [CW-1:0]    count
);

  generate
    if (CYCLES == 0) begin : g_bypass
      // zero depth degenerates to wires; clocking and control inputs are irrelevant
      assign out       = in;
      assign valid_out = valid_in;
      assign count     = '0;
    end else begin : g_pipe
      logic [WIDTH-1:0]  data_q [CYCLES];
      logic [CYCLES-1:0] valid_q;
      logic [CYCLES-1:0] valid_d;
      logic [CW-1:0]     count_q;
      logic [CW-1:0]     count_d;

      // next valid vector and its popcount, so count updates in the same edge as the valid bits
      always_comb begin
        valid_d = valid_q;
        if (flush) begin
          valid_d = '0;
        end else if (en) begin
          valid_d[0] = valid_in;
          for (int i = 1; i < CYCLES; i++) begin
            valid_d[i] = valid_q[i-1];
          end
        end
        count_d = '0;
        for (int i = 0; i < CYCLES; i++) begin
          count_d = count_d + CW'(valid_d[i]);
        end
      end

      // data stages shift on en only; flush leaves data alone
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < CYCLES; i++) begin
            data_q[i] <= RESET_VALUE;
          end
        end else if (en) begin
          data_q[0] <= in;
          for (int i = 1; i < CYCLES; i++) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end

      // valid bits and occupancy register
      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_q <= '0;
          count_q <= '0;
        end else begin
          valid_q <= valid_d;
          count_q <= count_d;
        end
      end

      assign out       = data_q[CYCLES-1];
      assign valid_out = valid_q[CYCLES-1];
      assign count     = count_q;
    end
  endgenerate

endmodule
